// File: rtl/fifo_pkg.sv
// Shared defaults and a sizing helper for the fifo block.
package fifo_pkg;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FIFO_DW_DEF    = 8;

  // The occupancy counter must hold 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo: one synchronous write port and one registered read port.
module fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The array is left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with a 1-cycle registered read.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = FIFO_DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ok, rd_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Blocked requests drop out here, which also resolves the both-active corner cases.
  assign wr_ok = wren && !full;
  assign rd_ok = rden && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wren && full)  overflow  <= 1'b1;
      if (rden && empty) underflow <= 1'b1;
    end
  end
`endif

  fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (i_data),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (o_data)
  );
endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo at default DEPTH=8, DATA_WIDTH=8.
module tb_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wren, rden;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       full, empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wren     (wren),
    .rden     (rden),
    .i_data   (i_data),
    .o_data   (o_data),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .full     (full),
    .empty    (empty)
  );

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wren = w; rden = r; i_data = d;
  endtask

  task automatic test_reset();
    drive(1, 0, 8'h55); cyc();
    drive(0, 1, 8'h00); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'h55) begin n_err++; $display("FAIL pre_reset_read o_data=%h exp=55", o_data); end
    drive(1, 0, 8'h66); cyc();
    drive(0, 0, 8'h00);
    #2 rst_n = 1'b0; #1;
    n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_chk++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
    n_chk++; if (o_data !== 8'h00) begin n_err++; $display("FAIL reset_odata got=%h exp=00", o_data); end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
`endif
    cyc(); rst_n = 1'b1;
    cyc();
    n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_discard empty=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 8'(i)); cyc();
      n_chk++; if (empty !== 1'b0) begin n_err++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
      n_chk++; if (full !== (i == 8)) begin n_err++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 8)); end
    end
    drive(0, 0, 8'h00);
  endtask

  task automatic test_overflow();
    drive(1, 0, 8'd9); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got=%b exp=1", full); end
    n_chk++; if (dut.count !== 4'd8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", dut.count); end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`endif
    cyc();
    n_chk++; if (o_data !== 8'h00) begin n_err++; $display("FAIL hold_no_read o_data=%h exp=00", o_data); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 8'h00); cyc();
      n_chk++; if (o_data !== 8'(i)) begin n_err++; $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, o_data, i); end
      n_chk++; if (full !== 1'b0) begin n_err++; $display("FAIL drain_full i=%0d got=%b exp=0", i, full); end
      n_chk++; if (empty !== (i == 8)) begin n_err++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, empty, (i == 8)); end
    end
    drive(0, 0, 8'h00);
  endtask

  task automatic test_underflow();
    drive(0, 1, 8'h00); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'd8) begin n_err++; $display("FAIL udf_hold got=%0d exp=8", o_data); end
    n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL udf_empty got=%b exp=1", empty); end
`ifdef FIFO_ERR_FLAGS_EN
    n_chk++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got=%b exp=1", underflow); end
`endif
    drive(1, 0, 8'h0A); cyc();
    drive(0, 1, 8'h00); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'h0A) begin n_err++; $display("FAIL udf_ptr got=%h exp=0a", o_data); end
  endtask

  task automatic test_both_empty();
    drive(1, 1, 8'h3C); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'h0A) begin n_err++; $display("FAIL be_hold got=%h exp=0a", o_data); end
    n_chk++; if (empty !== 1'b0) begin n_err++; $display("FAIL be_empty got=%b exp=0", empty); end
    drive(0, 1, 8'h00); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'h3C) begin n_err++; $display("FAIL be_data got=%h exp=3c", o_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 8'(10 + i)); cyc(); end
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 8'(14 + k)); cyc();
      n_chk++; if (o_data !== 8'(10 + k)) begin n_err++; $display("FAIL b2b_data k=%0d got=%0d exp=%0d", k, o_data, 10 + k); end
      n_chk++; if (dut.count !== 4'd4) begin n_err++; $display("FAIL b2b_count k=%0d got=%0d exp=4", k, dut.count); end
      n_chk++; if ({full, empty} !== 2'b00) begin n_err++; $display("FAIL b2b_flags k=%0d got=%b exp=00", k, {full, empty}); end
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 8'h00); cyc();
      n_chk++; if (o_data !== 8'(20 + k)) begin n_err++; $display("FAIL b2b_tail k=%0d got=%0d exp=%0d", k, o_data, 20 + k); end
    end
    drive(0, 0, 8'h00);
  endtask

  task automatic test_both_full();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 8'(8'h80 + i)); cyc(); end
    drive(1, 1, 8'hFF); cyc();
    drive(0, 0, 8'h00);
    n_chk++; if (o_data !== 8'h80) begin n_err++; $display("FAIL bf_data got=%h exp=80", o_data); end
    n_chk++; if (full !== 1'b0) begin n_err++; $display("FAIL bf_full got=%b exp=0", full); end
    n_chk++; if (dut.count !== 4'd7) begin n_err++; $display("FAIL bf_count got=%0d exp=7", dut.count); end
    for (int i = 1; i < 8; i++) begin
      drive(0, 1, 8'h00); cyc();
      n_chk++; if (o_data !== 8'(8'h80 + i)) begin n_err++; $display("FAIL bf_drain i=%0d got=%h exp=%h", i, o_data, 8'(8'h80 + i)); end
    end
    drive(0, 0, 8'h00);
    n_chk++; if (empty !== 1'b1) begin n_err++; $display("FAIL bf_empty got=%b exp=1", empty); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00);
    repeat (2) cyc();
    rst_n = 1'b1;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_both_empty();
    test_back_to_back();
    test_both_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
